axi_burst_addr_gen: RTL
=======================

# axi_burst_addr_gen

Per-beat address sequencer for the AXI slave write/read datapath. It accepts one AXI burst command (address, length, size, burst type) and emits one beat descriptor per transfer, in order. Each descriptor carries the beat address and transfer size that feed the byte-enable decoder directly downstream, which turns `ADDR[11:0]`/`SIZE` into an 8-bit lane strobe for the 64-bit data bus.

## Interface
- `ADDR_WIDTH`, default 32: command and beat address width; must be ≥ 12.
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESETn`  in  1  asynchronous, active-low reset.
- `CMD_VALID`  in  1  burst command valid.
- `CMD_READY`  out  1  block can accept a command.
- `CMD_ADDR`  in  `ADDR_WIDTH`  start address, possibly unaligned.
- `CMD_LEN`  in  8  beats minus 1 (AXI4 encoding).
- `CMD_SIZE`  in  3  log2 bytes per beat.
- `CMD_BURST`  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `BEAT_VALID`  out  1  beat descriptor valid.
- `BEAT_READY`  in  1  downstream accepts the beat.
- `BEAT_ADDR`  out  `ADDR_WIDTH`  beat address; bits [11:0] go to the byte-enable decoder.
- `BEAT_SIZE`  out  3  beat size; goes to the byte-enable decoder.
- `BEAT_LAST`  out  1  final beat of the burst.

## Operation
- FSM has 2 states. IDLE: `CMD_READY`=1 and `BEAT_VALID`=0. BURST: `CMD_READY`=0 and `BEAT_VALID`=1.
- IDLE→BURST on `CMD_VALID && CMD_READY`. The block registers addr, len, size and burst, and clears the beat counter.
- BURST→IDLE on `BEAT_VALID && BEAT_READY && BEAT_LAST`.
- Size clamp: `CMD_SIZE` > 3 is clamped to 3 for both `BEAT_SIZE` and the increment. Beat byte count is B = 1<<size.
- Burst type 11 is treated as INCR.
- First beat: `BEAT_ADDR` = `CMD_ADDR` unmodified, in every burst mode.
- Address update on each accepted beat:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(B-1)) + B, computed on bits [11:0] only. Bits above 11 are held from `CMD_ADDR`, so the address wraps inside the 4 KB page and never carries into the upper bits.
  - WRAP with `CMD_LEN` ∈ {1,3,7,15}: W = B*(len+1). next = (addr & ~(W-1)) | ((aligned(addr)+B) & (W-1)).
  - WRAP with any other `CMD_LEN`: treated as INCR.
- Beat counter is 8 bits and increments per accepted beat. `BEAT_LAST` = (count == len).
- When len=0, the first beat is also the last beat.

## Timing
- Reset values, applied asynchronously on `ARESETn`=0:
  - `CMD_READY`=0, `BEAT_VALID`=0, `BEAT_LAST`=0, `BEAT_ADDR`=0, `BEAT_SIZE`=0.
  - State is IDLE.
- `CMD_READY` is registered. It rises on the first `ACLK` edge after `ARESETn` deasserts.
- Command accepted at edge N → first beat has `BEAT_VALID`=1 after edge N with no extra delay, so it is visible in cycle N+1.
- Stall: while `BEAT_VALID`=1 and `BEAT_READY`=0, `BEAT_ADDR`, `BEAT_SIZE` and `BEAT_LAST` are held stable. `BEAT_VALID` is never withdrawn.
- Throughput is 1 beat per cycle when `BEAT_READY` is held high.
- Last beat accepted at edge M → `CMD_READY`=1 from cycle M+1. This gives exactly one idle cycle between bursts; no overlap.
- A `CMD_VALID` arriving during BURST is not accepted and waits, since `CMD_READY`=0.
- Reset mid-burst aborts the burst immediately. No beat is emitted after reset release until a new command is accepted.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- INCR, addr 0x100, size 2, len 3 → beats 0x100, 0x104, 0x108, 0x10C; `BEAT_LAST` only on 0x10C; `CMD_READY` back high one cycle later.
- Unaligned INCR, addr 0x103, size 2, len 2 → beats 0x103, 0x104, 0x108; `BEAT_SIZE`=2 on every beat.
- WRAP, addr 0x10C, size 2, len 3 → 0x10C, 0x100, 0x104, 0x108.
- WRAP with illegal len=2, addr 0x10C, size 2 → 0x10C, 0x110, 0x114.
- FIXED, addr 0x2A, size 0, len 2 → three beats at 0x2A.
- Page wrap: INCR, addr 0x0000_1FF8, size 3, len 1 → 0x0000_1FF8, then 0x0000_1000.
- Size clamp: `CMD_SIZE`=5, addr 0x40, len 1 → `BEAT_SIZE`=3; beats 0x40, 0x48.
- Backpressure: hold `BEAT_READY`=0 for 3 cycles mid-burst → outputs frozen; no beat lost or duplicated.
- Reset mid-burst: assert `ARESETn`=0 at beat 2 of 4.
  - During reset: `BEAT_VALID`=0 and `CMD_READY`=0.
  - After release: `CMD_READY`=1 one edge later, and no residual beats.

Source files
------------

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - AXI burst to per-beat address/size descriptor sequencer
module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [7:0]            CMD_LEN,
    input  logic [2:0]            CMD_SIZE,
    input  logic [1:0]            CMD_BURST,
    output logic                  BEAT_VALID,
    input  logic                  BEAT_READY,
    output logic [ADDR_WIDTH-1:0] BEAT_ADDR,
    output logic [2:0]            BEAT_SIZE,
    output logic                  BEAT_LAST
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                  state;
    logic [7:0]              len_q;
    logic [7:0]              count;
    logic [1:0]              burst_q;
    logic [2:0]              size_clamped;
    logic [11:0]             step;
    logic [11:0]             low;
    logic [11:0]             aligned;
    logic [11:0]             incr_low;
    logic [11:0]             wrap_mask;
    logic [11:0]             next_low;
    logic                    wrap_legal;
    logic [ADDR_WIDTH-1:0]   next_addr;

    assign size_clamped = (CMD_SIZE > 3'd3) ? 3'd3 : CMD_SIZE;

    // Address arithmetic stays inside the 4 KB page; upper bits are carried unchanged.
    always_comb begin
        step       = 12'd1 << BEAT_SIZE;
        low        = BEAT_ADDR[11:0];
        aligned    = low & ~(step - 12'd1);
        incr_low   = aligned + step;
        wrap_legal = (burst_q == 2'b10) &&
                     ((len_q == 8'd1) || (len_q == 8'd3) ||
                      (len_q == 8'd7) || (len_q == 8'd15));
        wrap_mask  = (step * ({4'd0, len_q} + 12'd1)) - 12'd1;
        next_low   = incr_low;
        if (burst_q == 2'b00) begin
            next_low = low;
        end else if (wrap_legal) begin
            next_low = (low & ~wrap_mask) | (incr_low & wrap_mask);
        end
        next_addr        = BEAT_ADDR;
        next_addr[11:0]  = next_low;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            CMD_READY  <= 1'b0;
            BEAT_VALID <= 1'b0;
            BEAT_LAST  <= 1'b0;
            BEAT_ADDR  <= '0;
            BEAT_SIZE  <= 3'd0;
            len_q      <= 8'd0;
            count      <= 8'd0;
            burst_q    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_READY && CMD_VALID) begin
                        state      <= BURST;
                        CMD_READY  <= 1'b0;
                        BEAT_VALID <= 1'b1;
                        BEAT_ADDR  <= CMD_ADDR;
                        BEAT_SIZE  <= size_clamped;
                        BEAT_LAST  <= (CMD_LEN == 8'd0);
                        len_q      <= CMD_LEN;
                        burst_q    <= CMD_BURST;
                        count      <= 8'd0;
                    end else begin
                        CMD_READY  <= 1'b1;
                    end
                end
                BURST: begin
                    if (BEAT_READY) begin
                        if (BEAT_LAST) begin
                            state      <= IDLE;
                            BEAT_VALID <= 1'b0;
                            BEAT_LAST  <= 1'b0;
                            CMD_READY  <= 1'b1;
                        end else begin
                            count      <= count + 8'd1;
                            BEAT_LAST  <= ((count + 8'd1) == len_q);
                            BEAT_ADDR  <= next_addr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
